uart_tx_fifo: RTL and testbench

Byte queue and launch sequencer that sits directly upstream of the UART transmitter. It accepts bytes from the core over a valid/ready write port, buffers up to DEPTH of them, and presents them one at a time to the transmitter's data/start_tx/ready handshake. The transmitter's state machine only advances on the baud enable, so this block holds each launch request until the transmitter acknowledges it. This frees producers from tracking baud timing.

---
 rtl/uart_tx_fifo.sv | 80 ++++++++
 tb/tb_uart_tx_fifo.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: byte FIFO feeding a UART transmitter through a held start/ready launch handshake
module uart_tx_fifo #(
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  wr_data,
  input  logic        wr_valid,
  output logic        wr_ready,
  output logic [7:0]  tx_data,
  output logic        tx_start,
  input  logic        tx_ready,
  output logic [AW:0] count,
  output logic        empty,
  output logic        full,
  output logic        overflow
);
  typedef enum logic [1:0] {IDLE, LAUNCH, BUSY} state_t;
  state_t        r_state;
  logic [7:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr, r_rd_ptr;
  logic [AW:0]   r_count;
  logic [7:0]    r_tx_data;
  logic          r_tx_start, r_overflow;
  logic          w_push, w_pop, w_full, w_empty;
  assign w_full   = r_count == (AW+1)'(DEPTH);
  assign w_empty  = r_count == '0;
  assign w_push   = wr_valid && !w_full;
  assign wr_ready = !w_full;
  assign full     = w_full;
  assign empty    = w_empty;
  assign count    = r_count;
  assign tx_data  = r_tx_data;
  assign tx_start = r_tx_start;
  assign overflow = r_overflow;
  // pop only from IDLE with data queued and the transmitter reading as definitely ready
  always_comb begin
    w_pop = 1'b0;
    if (r_state == IDLE && !w_empty && tx_ready == 1'b1) w_pop = 1'b1;
  end
  // byte storage, written only on an accepted push
  always_ff @(posedge clk) begin
    if (rst_n && w_push) r_mem[r_wr_ptr] <= wr_data;
  end
  // pointers, occupancy, sticky overflow and the launch sequencer
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_tx_data  <= 8'h00;
      r_tx_start <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop) r_rd_ptr <= r_rd_ptr + AW'(1);
      if (w_push && !w_pop) r_count <= r_count + (AW+1)'(1);
      else if (!w_push && w_pop) r_count <= r_count - (AW+1)'(1);
      if (wr_valid && w_full) r_overflow <= 1'b1;
      case (r_state)
        IDLE: if (w_pop) begin
          r_tx_data  <= r_mem[r_rd_ptr];
          r_tx_start <= 1'b1;
          r_state    <= LAUNCH;
        end
        LAUNCH: if (tx_ready == 1'b0) begin
          r_tx_start <= 1'b0;
          r_state    <= BUSY;
        end
        BUSY: if (tx_ready == 1'b1) r_state <= IDLE;
        default: begin
          r_tx_start <= 1'b0;
          r_state    <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: scenario tasks plus a queue scoreboard and randomized transmitter model
module tb_uart_tx_fifo;
  localparam int DEPTH = 16;
  logic       clk = 0;
  logic       rst_n = 0;
  logic [7:0] wr_data = 0;
  logic       wr_valid = 0;
  logic       wr_ready;
  logic [7:0] tx_data;
  logic       tx_start;
  logic       tx_ready = 0;
  logic [4:0] count;
  logic       empty, full, overflow;

  uart_tx_fifo #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .tx_data(tx_data), .tx_start(tx_start), .tx_ready(tx_ready), .count(count),
    .empty(empty), .full(full), .overflow(overflow)
  );

  always #5 clk = ~clk;

  int         total = 0;
  int         bad = 0;
  logic [7:0] q[$];
  logic [7:0] launched[$];
  logic       m_ovf = 0;
  logic       prev_start = 0;
  logic [7:0] last_data = 0;
  logic       ready_drv = 0;
  logic       tm_auto = 0;
  int         tm_phase = 0;
  int         tm_wait = 0;
  int         tm_busy = 0;

  task automatic tm_drive();
    if (tm_phase == 0) begin
      if (tx_start === 1'b1) begin
        if (tm_wait > 0) tm_wait--;
        else begin
          tm_phase = 1;
          tm_busy = $urandom_range(1, 5);
        end
      end
    end else if (tm_busy > 0) tm_busy--;
    else begin
      tm_phase = 0;
      tm_wait = $urandom_range(0, 2);
    end
    ready_drv = (tm_phase == 0);
  endtask

  task automatic step(input logic v, input logic [7:0] d);
    logic acc;
    logic rdy;
    if (tm_auto) tm_drive();
    wr_valid = v;
    wr_data = d;
    tx_ready = ready_drv;
    rdy = ready_drv;
    total++;
    if (wr_ready !== (q.size() != DEPTH)) begin
      bad++;
      $display("FAIL wr_ready got=%b exp=%b", wr_ready, q.size() != DEPTH);
    end
    acc = v && (q.size() != DEPTH);
    if (v && q.size() == DEPTH) m_ovf = 1;
    @(posedge clk);
    #1;
    wr_valid = 0;
    if (tx_start === 1'b1 && !prev_start) begin
      total++;
      if (q.size() == 0) begin
        bad++;
        $display("FAIL pop_from_empty tx_data=%h", tx_data);
      end else begin
        if (tx_data !== q[0]) begin
          bad++;
          $display("FAIL launch_order got=%h exp=%h", tx_data, q[0]);
        end
        launched.push_back(q[0]);
        last_data = q.pop_front();
      end
    end else begin
      total++;
      if (tx_data !== last_data) begin
        bad++;
        $display("FAIL tx_data_hold got=%h exp=%h", tx_data, last_data);
      end
    end
    if (acc) q.push_back(d);
    if (prev_start) begin
      total++;
      if (tx_start !== rdy) begin
        bad++;
        $display("FAIL launch_hold tx_start got=%b exp=%b", tx_start, rdy);
      end
    end
    total++;
    if (count !== 5'(q.size()) || empty !== (q.size() == 0) || full !== (q.size() == DEPTH) || overflow !== m_ovf) begin
      bad++;
      $display("FAIL flags count=%0d/%0d empty=%b full=%b ovf=%b/%b", count, q.size(), empty, full, overflow, m_ovf);
    end
    prev_start = tx_start;
  endtask

  task automatic do_reset();
    rst_n = 0;
    wr_valid = 0;
    tx_ready = ready_drv;
    @(posedge clk);
    #1;
    rst_n = 1;
    q.delete();
    launched.delete();
    m_ovf = 0;
    prev_start = 0;
    last_data = 0;
    tm_phase = 0;
    tm_wait = 0;
  endtask

  task automatic check_reset_values(input string tag);
    total++;
    if (tx_start !== 0 || tx_data !== 8'h00 || wr_ready !== 1 || count !== 0 || empty !== 1 || full !== 0 || overflow !== 0) begin
      bad++;
      $display("FAIL %s start=%b data=%h wr_ready=%b count=%0d empty=%b full=%b ovf=%b exp 0 00 1 0 1 0 0",
               tag, tx_start, tx_data, wr_ready, count, empty, full, overflow);
    end
  endtask

  task automatic drain();
    bit done = 0;
    tm_auto = 1;
    for (int i = 0; i < 3000; i++) begin
      if (q.size() == 0 && tx_start === 1'b0 && tm_phase == 0) begin
        done = 1;
        break;
      end
      step(0, 8'h00);
    end
    tm_auto = 0;
    total++;
    if (!done) begin
      bad++;
      $display("FAIL drain_timeout left=%0d", q.size());
    end
  endtask

  task automatic test_reset();
    ready_drv = 0;
    tm_auto = 0;
    do_reset();
    check_reset_values("reset_values");
  endtask

  task automatic test_single();
    ready_drv = 1;
    do_reset();
    step(1, 8'hA5);
    total++;
    if (tx_start !== 0) begin
      bad++;
      $display("FAIL single_no_fallthrough tx_start got=%b exp=0", tx_start);
    end
    step(0, 8'h00);
    total++;
    if (tx_start !== 1 || tx_data !== 8'hA5) begin
      bad++;
      $display("FAIL single_launch start=%b data=%h exp 1 a5", tx_start, tx_data);
    end
    repeat (4) step(0, 8'h00);
    ready_drv = 0;
    step(0, 8'h00);
    total++;
    if (tx_start !== 0 || count !== 0) begin
      bad++;
      $display("FAIL single_ack start=%b count=%0d exp 0 0", tx_start, count);
    end
    ready_drv = 1;
    step(0, 8'h00);
  endtask

  task automatic test_burst_overflow();
    ready_drv = 0;
    tm_auto = 0;
    do_reset();
    for (int i = 1; i <= 16; i++) step(1, 8'(i));
    total++;
    if (full !== 1 || wr_ready !== 0 || count !== 16) begin
      bad++;
      $display("FAIL burst_full full=%b wr_ready=%b count=%0d exp 1 0 16", full, wr_ready, count);
    end
    step(1, 8'hFF);
    step(0, 8'h00);
    total++;
    if (overflow !== 1 || count !== 16) begin
      bad++;
      $display("FAIL overflow ovf=%b count=%0d exp 1 16", overflow, count);
    end
    drain();
    total++;
    if (launched.size() != 16) begin
      bad++;
      $display("FAIL burst_len got=%0d exp=16", launched.size());
    end else
      for (int i = 0; i < 16; i++) begin
        total++;
        if (launched[i] !== 8'(i + 1)) begin
          bad++;
          $display("FAIL burst_seq[%0d] got=%h exp=%h", i, launched[i], 8'(i + 1));
        end
      end
    total++;
    if (empty !== 1 || overflow !== 1) begin
      bad++;
      $display("FAIL burst_end empty=%b ovf=%b exp 1 1", empty, overflow);
    end
  endtask

  task automatic test_simul();
    ready_drv = 0;
    tm_auto = 0;
    do_reset();
    for (int i = 0; i < 3; i++) step(1, 8'($urandom));
    for (int r = 0; r < 20; r++) begin
      ready_drv = 1;
      step(1, 8'($urandom));
      total++;
      if (count !== 3 || tx_start !== 1) begin
        bad++;
        $display("FAIL simul_push_pop round=%0d count=%0d start=%b exp 3 1", r, count, tx_start);
      end
      ready_drv = 0;
      step(0, 8'h00);
      ready_drv = 1;
      step(0, 8'h00);
    end
    drain();
  endtask

  task automatic test_slow_ack();
    ready_drv = 1;
    tm_auto = 0;
    do_reset();
    step(1, 8'h3C);
    step(1, 8'hC3);
    total++;
    if (tx_start !== 1 || tx_data !== 8'h3C || count !== 1) begin
      bad++;
      $display("FAIL slow_launch start=%b data=%h count=%0d exp 1 3c 1", tx_start, tx_data, count);
    end
    repeat (200) step(0, 8'h00);
    total++;
    if (tx_start !== 1 || tx_data !== 8'h3C || count !== 1) begin
      bad++;
      $display("FAIL slow_hold start=%b data=%h count=%0d exp 1 3c 1", tx_start, tx_data, count);
    end
    drain();
  endtask

  task automatic test_reset_mid();
    ready_drv = 0;
    tm_auto = 0;
    do_reset();
    for (int i = 0; i < 6; i++) step(1, 8'($urandom));
    ready_drv = 1;
    step(0, 8'h00);
    total++;
    if (tx_start !== 1 || count !== 5) begin
      bad++;
      $display("FAIL mid_setup start=%b count=%0d exp 1 5", tx_start, count);
    end
    do_reset();
    check_reset_values("mid_reset_values");
    for (int i = 0; i < 10; i++) begin
      step(0, 8'h00);
      total++;
      if (tx_start !== 0) begin
        bad++;
        $display("FAIL mid_no_launch cycle=%0d start=%b exp 0", i, tx_start);
      end
    end
    step(1, 8'h5A);
    step(0, 8'h00);
    total++;
    if (tx_start !== 1 || tx_data !== 8'h5A) begin
      bad++;
      $display("FAIL mid_relaunch start=%b data=%h exp 1 5a", tx_start, tx_data);
    end
    drain();
  endtask

  task automatic test_random();
    int n;
    ready_drv = 1;
    do_reset();
    tm_auto = 1;
    for (int i = 0; i < 800; i++) step($urandom_range(0, 2) != 0, 8'($urandom));
    n = launched.size() + q.size();
    drain();
    total++;
    if (launched.size() != n || q.size() != 0) begin
      bad++;
      $display("FAIL random_drain launched=%0d exp=%0d", launched.size(), n);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_burst_overflow();
    test_simul();
    test_slow_ack();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
